// File: rtl/datapath_sequencer_if.sv
// Interface bundling the instruction handshake and the datapath control pins
// between the instruction source/datapath and the datapath_sequencer.
// master: instruction source + datapath side; slave: the sequencer.
interface datapath_sequencer_if #(
  parameter int IW = 16
);
  logic          s;
  logic [IW-1:0] instr;
  logic          w;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;
  logic          vsel;
  logic          write;
  logic [1:0]    ALUop;
  logic [1:0]    shift;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic [IW-1:0] datapath_in;
  logic          illegal;

  modport master (
    output s, instr,
    input  w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
    input  ALUop, shift, readnum, writenum, datapath_in, illegal
  );

  modport slave (
    input  s, instr,
    output w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
    output ALUop, shift, readnum, writenum, datapath_in, illegal
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Moore FSM sequencing the lab datapath (regfile, A/B/C, shifter, ALU, status).
// One 16-bit instruction is captured per start handshake in WAIT and played
// out as a fixed sequence of control states; w=1 only while idle in WAIT.
// All outputs are decoded from state and the captured instruction and are
// forced low while reset is high, so a reset edge never commits a write.
// Build option: define SEQ_ILLEGAL_TRAP_EN to send undecodable instructions
// to a sticky TRAP state (illegal=1); otherwise they retire as a NOP.
module datapath_sequencer #(
  parameter int IW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_WAIT      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_WRITE_IMM = 3'd2;
  localparam logic [2:0] ST_GET_A     = 3'd3;
  localparam logic [2:0] ST_GET_B     = 3'd4;
  localparam logic [2:0] ST_CALC      = 3'd5;
  localparam logic [2:0] ST_WRITE_REG = 3'd6;
  localparam logic [2:0] ST_TRAP      = 3'd7;

  // {opc, op} encodings of the supported instructions
  localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
  localparam logic [4:0] OP_MOV_REG = 5'b110_00;
  localparam logic [4:0] OP_MVN     = 5'b101_11;
  localparam logic [4:0] OP_ADD     = 5'b101_00;
  localparam logic [4:0] OP_CMP     = 5'b101_01;
  localparam logic [4:0] OP_AND     = 5'b101_10;

  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic [IW-1:0] ir_r;

  logic [4:0]    opcode_s;
  logic [1:0]    op_s;
  logic [2:0]    rn_s;
  logic [2:0]    rd_s;
  logic [1:0]    sh_s;
  logic [2:0]    rm_s;
  logic [7:0]    imm8_s;

  assign opcode_s = ir_r[15:11];
  assign op_s     = ir_r[12:11];
  assign rn_s     = ir_r[10:8];
  assign rd_s     = ir_r[7:5];
  assign sh_s     = ir_r[4:3];
  assign rm_s     = ir_r[2:0];
  assign imm8_s   = ir_r[7:0];

  // State register and instruction capture on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_WAIT;
      ir_r    <= {IW{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_WAIT) && bus.s) begin
        ir_r <= bus.instr;
      end
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (bus.s) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_MOV_IMM:                 next_state_s = ST_WRITE_IMM;
          OP_MOV_REG, OP_MVN:         next_state_s = ST_GET_B;
          OP_ADD, OP_CMP, OP_AND:     next_state_s = ST_GET_A;
`ifdef SEQ_ILLEGAL_TRAP_EN
          default:                    next_state_s = ST_TRAP;
`else
          default:                    next_state_s = ST_WAIT;
`endif
        endcase
      end
      ST_WRITE_IMM: next_state_s = ST_WAIT;
      ST_GET_A:     next_state_s = ST_GET_B;
      ST_GET_B:     next_state_s = ST_CALC;
      ST_CALC: begin
        if (opcode_s == OP_CMP) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_WRITE_REG;
        end
      end
      ST_WRITE_REG: next_state_s = ST_WAIT;
`ifdef SEQ_ILLEGAL_TRAP_EN
      ST_TRAP:      next_state_s = ST_TRAP;
`endif
      default:      next_state_s = ST_WAIT;
    endcase
  end

  // Moore output decode, held at zero while reset is asserted
  always_comb begin
    bus.w           = 1'b0;
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.loadc       = 1'b0;
    bus.loads       = 1'b0;
    bus.asel        = 1'b0;
    bus.bsel        = 1'b0;
    bus.vsel        = 1'b0;
    bus.write       = 1'b0;
    bus.ALUop       = 2'b00;
    bus.shift       = 2'b00;
    bus.readnum     = 3'd0;
    bus.writenum    = 3'd0;
    bus.datapath_in = {IW{1'b0}};
    bus.illegal     = 1'b0;
    if (reset) begin
      bus.w = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: bus.w = 1'b1;
        ST_WRITE_IMM: begin
          bus.vsel        = 1'b1;
          bus.write       = 1'b1;
          bus.writenum    = rn_s;
          bus.datapath_in = {{8{imm8_s[7]}}, imm8_s};
        end
        ST_GET_A: begin
          bus.readnum = rn_s;
          bus.loada   = 1'b1;
        end
        ST_GET_B: begin
          bus.readnum = rm_s;
          bus.loadb   = 1'b1;
        end
        ST_CALC: begin
          bus.shift = sh_s;
          case (opcode_s)
            OP_MOV_REG: begin
              // A input forced to zero so ADD passes the shifted B through
              bus.asel  = 1'b1;
              bus.ALUop = 2'b00;
              bus.loadc = 1'b1;
            end
            OP_MVN: begin
              bus.ALUop = 2'b11;
              bus.loadc = 1'b1;
            end
            OP_CMP: begin
              bus.ALUop = 2'b01;
              bus.loads = 1'b1;
            end
            default: begin
              bus.ALUop = op_s;
              bus.loadc = 1'b1;
            end
          endcase
        end
        ST_WRITE_REG: begin
          bus.write    = 1'b1;
          bus.writenum = rd_s;
        end
`ifdef SEQ_ILLEGAL_TRAP_EN
        ST_TRAP: bus.illegal = 1'b1;
`endif
        default: bus.w = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench: the sequencer drives a small behavioural lab datapath
// (8x16 regfile, A/B/C, shifter, ALU, Z flag); register and status contents
// plus handshake timing are compared against hand-computed values.
module tb_datapath_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  datapath_sequencer_if bus ();

  datapath_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural datapath ----------------
  logic [15:0] rf [0:7];
  logic [15:0] ra, rb, rc;
  logic        z;
  logic [15:0] data_out, sout, ain, bin, alu_out;

  always_comb begin
    data_out = rf[bus.readnum];
    case (bus.shift)
      2'b00:   sout = rb;
      2'b01:   sout = {rb[14:0], 1'b0};
      2'b10:   sout = {1'b0, rb[15:1]};
      default: sout = {rb[15], rb[15:1]};
    endcase
    ain = bus.asel ? 16'h0000 : ra;
    bin = bus.bsel ? 16'h0000 : sout;
    case (bus.ALUop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (bus.write) rf[bus.writenum] <= bus.vsel ? bus.datapath_in : rc;
    if (bus.loada) ra <= data_out;
    if (bus.loadb) rb <= data_out;
    if (bus.loadc) rc <= alu_out;
    if (bus.loads) z  <= (alu_out == 16'h0000);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from WAIT and count cycles with w low (called at a negedge)
  task automatic run(input logic [15:0] ins, input int exp_low, input string tag);
    int low;
    bus.s = 1'b1;
    bus.instr = ins;
    @(negedge clk);
    bus.s = 1'b0;
    bus.instr = 16'($urandom);
    low = 0;
    while (bus.w !== 1'b1 && low < 16) begin
      low++;
      @(negedge clk);
    end
    chk({tag, "_wlow"}, 16'(low), 16'(exp_low));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] snap [0:7];
  int cyc;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.s = 1'b0;
    bus.instr = 16'h0000;
    repeat (2) @(negedge clk);
    chk("w_gated_in_reset", {15'd0, bus.w}, 16'h0000);
    reset = 1'b0;
    #1;
    chk("reset_w", {15'd0, bus.w}, 16'h0001);
    chk("reset_write", {15'd0, bus.write}, 16'h0000);
    chk("reset_loads", {12'd0, bus.loada, bus.loadb, bus.loadc, bus.loads}, 16'h0000);
    chk("reset_dp_in", bus.datapath_in, 16'h0000);
    chk("reset_illegal", {15'd0, bus.illegal}, 16'h0000);
    @(negedge clk);

    // MOV R3,#42 and MOV R5,#13
    run(16'hD32A, 2, "mov_r3");
    chk("r3", rf[3], 16'd42);
    run(16'hD50D, 2, "mov_r5");
    chk("r5", rf[5], 16'd13);

    // s held high: MOV R4,#4 then MOV R2,#7 accepted on the first WAIT edge
    bus.s = 1'b1;
    bus.instr = 16'hD404;
    @(negedge clk);
    @(negedge clk);
    chk("wimm_dp_in", bus.datapath_in, 16'h0004);
    chk("wimm_ctrl", {13'd0, bus.write, bus.vsel, bus.loadc}, 16'h0006);
    chk("wimm_writenum", {13'd0, bus.writenum}, 16'h0004);
    @(negedge clk);
    chk("back_to_wait", {15'd0, bus.w}, 16'h0001);
    bus.instr = 16'hD207;
    @(negedge clk);
    chk("held_s_accept", {15'd0, bus.w}, 16'h0000);
    bus.s = 1'b0;
    bus.instr = 16'($urandom);
    cyc = 0;
    while (bus.w !== 1'b1 && cyc < 16) begin
      cyc++;
      @(negedge clk);
    end
    chk("held_s_done", 16'(cyc), 16'd2);
    chk("r4_imm", rf[4], 16'd4);
    chk("r2_imm", rf[2], 16'd7);

    // ADD R2,R3,R5 interrupted by reset in WRITE_REG
    bus.s = 1'b1;
    bus.instr = 16'hA345;
    @(negedge clk);
    bus.s = 1'b0;
    bus.instr = 16'($urandom);
    cyc = 1;
    while (!(bus.write === 1'b1 && bus.vsel === 1'b0) && cyc < 16) begin
      cyc++;
      @(negedge clk);
    end
    chk("add_reach_wreg", 16'(cyc), 16'd5);
    chk("add_wreg_writenum", {13'd0, bus.writenum}, 16'h0002);
    reset = 1'b1;
    #1;
    chk("wreg_write_gated", {15'd0, bus.write}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_w", {15'd0, bus.w}, 16'h0001);
    chk("post_reset_write", {15'd0, bus.write}, 16'h0000);
    chk("r2_no_write", rf[2], 16'd7);
    @(negedge clk);

    // Full ADD, MOV reg with LSL, negative immediate, MVN, AND
    run(16'hA345, 5, "add");
    chk("r2_add", rf[2], 16'd55);
    run(16'hC0EB, 4, "mov_lsl");
    chk("r7_lsl", rf[7], 16'd84);
    run(16'hD1FF, 2, "mov_neg");
    chk("r1_sx", rf[1], 16'hFFFF);
    run(16'hB885, 4, "mvn");
    chk("r4_mvn", rf[4], 16'hFFF2);
    run(16'hB3C5, 5, "and");
    chk("r6_and", rf[6], 16'h0008);

    // CMP: status only, regfile untouched
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
    run(16'hAB05, 4, "cmp_ne");
    chk("z_ne", {15'd0, z}, 16'h0000);
    run(16'hAB03, 4, "cmp_eq");
    chk("z_eq", {15'd0, z}, 16'h0001);
    for (int i = 0; i < 8; i++) chk($sformatf("cmp_rf%0d", i), rf[i], snap[i]);

    // Undecodable instruction 0x0000
`ifdef SEQ_ILLEGAL_TRAP_EN
    bus.s = 1'b1;
    bus.instr = 16'h0000;
    @(negedge clk);
    bus.s = 1'b0;
    repeat (5) @(negedge clk);
    chk("trap_w", {15'd0, bus.w}, 16'h0000);
    chk("trap_illegal", {15'd0, bus.illegal}, 16'h0001);
    chk("trap_write", {15'd0, bus.write}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("trap_exit_w", {15'd0, bus.w}, 16'h0001);
    chk("trap_exit_illegal", {15'd0, bus.illegal}, 16'h0000);
`else
    bus.s = 1'b1;
    bus.instr = 16'h0000;
    @(negedge clk);
    bus.s = 1'b0;
    chk("nop_illegal", {15'd0, bus.illegal}, 16'h0000);
    @(negedge clk);
    chk("nop_w_back", {15'd0, bus.w}, 16'h0001);
    chk("nop_illegal_after", {15'd0, bus.illegal}, 16'h0000);
`endif
    for (int i = 0; i < 8; i++) chk($sformatf("illegal_rf%0d", i), rf[i], snap[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
